// File: rtl/common_p.sv
// common_p: shared clock-domain bundle carrying the clock, its cycle enable and sync reset
package common_p;
    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_dom_s;
endpackage

// File: rtl/edge_interval_sampler.sv
// edge_interval_sampler: synchronizes an async signal and measures the interval between
// qualified edges, emitting one strobed sample per accepted interval
module edge_interval_sampler #(
    parameter int COUNT_BIT_WIDTH = 8,
    parameter int SYNC_STAGES     = 2
) (
    input  common_p::clk_dom_s         sys_dom_i,
    input  logic                       clear_state_i,
    input  logic                       enable_i,
    input  logic [1:0]                 edge_select_i,
    input  logic [COUNT_BIT_WIDTH-1:0] min_interval_i,
    input  logic                       signal_i,
    output logic                       we_o,
    output logic [COUNT_BIT_WIDTH-1:0] data_o,
    output logic                       overflow_o,
    output logic                       locked_o
);
    localparam logic [1:0] IDLE      = 2'b00;
    localparam logic [1:0] ARMED     = 2'b01;
    localparam logic [1:0] MEASURING = 2'b10;
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);
    localparam logic [COUNT_BIT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_BIT_WIDTH-1:0] CNT_ONE = COUNT_BIT_WIDTH'(1);

    logic [SYNC_STAGES-1:0]     sync_q;
    logic                       hist_q;
    logic [PW-1:0]              prime_q, prime_d;
    logic [1:0]                 state_q, state_d;
    logic [COUNT_BIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_BIT_WIDTH-1:0] data_q, data_d;
    logic                       we_q, we_d;
    logic                       ovf_q, ovf_d;
    logic                       sig, primed, qual, sat, accept;

    assign sig    = sync_q[SYNC_STAGES-1];
    assign primed = prime_q == PRIME_DONE;
    assign qual   = primed & ((sig & ~hist_q & edge_select_i[0]) | (~sig & hist_q & edge_select_i[1]));
    assign sat    = cnt_q == CNT_MAX;
    assign accept = qual & ~sat & (cnt_q >= min_interval_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        we_d    = 1'b0;
        ovf_d   = ovf_q;
        prime_d = clear_state_i ? '0 : (primed ? prime_q : prime_q + PW'(1));
        if (clear_state_i) begin
            state_d = enable_i ? ARMED : IDLE;
            cnt_d   = '0;
            data_d  = '0;
            ovf_d   = 1'b0;
        end else if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            state_d = ARMED;
        end else if (state_q == ARMED) begin
            state_d = qual ? MEASURING : ARMED;
            cnt_d   = qual ? CNT_ONE : cnt_q;
        end else begin
            // a saturated interval is discarded but still restarts the count
            cnt_d  = qual && (sat || accept) ? CNT_ONE : (sat ? cnt_q : cnt_q + CNT_ONE);
            data_d = accept ? cnt_q : data_q;
            we_d   = accept;
            ovf_d  = ovf_q | (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge sys_dom_i.clk) begin
        if (sys_dom_i.sync_rst) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            prime_q <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (sys_dom_i.clk_en) begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], signal_i};
            hist_q  <= sig;
            prime_q <= prime_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ovf_q   <= ovf_d;
        end
    end

    assign we_o       = we_q;
    assign data_o     = data_q;
    assign overflow_o = ovf_q;
    assign locked_o   = state_q == MEASURING;
endmodule

// File: tb/tb_edge_interval_sampler.sv
// tb_edge_interval_sampler: directed stimulus with a sample scoreboard checked by a monitor
module tb_edge_interval_sampler;
    logic clk, clk_en, rst;
    logic clr, en, sig;
    logic [1:0] sel;
    logic [7:0] min_iv;
    logic we_o, overflow_o, locked_o;
    logic [7:0] data_o;
    common_p::clk_dom_s sys;
    int n_chk, n_fail;
    bit tog;
    logic [31:0] q[$];
    logic [31:0] e;

    assign sys = '{clk: clk, clk_en: clk_en, sync_rst: rst};

    edge_interval_sampler dut (
        .sys_dom_i(sys),
        .clear_state_i(clr),
        .enable_i(en),
        .edge_select_i(sel),
        .min_interval_i(min_iv),
        .signal_i(sig),
        .we_o(we_o),
        .data_o(data_o),
        .overflow_o(overflow_o),
        .locked_o(locked_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (tog) clk_en = ~clk_en;
    endtask

    task automatic half(input logic v, input int n, input int exp, input bit push);
        if (push) q.push_back(32'(exp));
        sig = v;
        repeat (n) step();
    endtask

    task automatic gper(input bit push);
        half(1'b1, 1, 20, push);
        half(1'b0, 1, 0, 1'b0);
        half(1'b1, 2, 0, 1'b0);
        half(1'b0, 16, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && clk_en && we_o) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_sample: got data_o=%0d expected no sample", data_o);
            end else begin
                e = q.pop_front();
                chk("sample", 32'(data_o), e);
            end
        end
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        tog = 1'b0;
        clk_en = 1'b1;
        rst = 1'b1;
        clr = 1'b0;
        en = 1'b1;
        sel = 2'b01;
        min_iv = 8'd0;
        sig = 1'b0;
        repeat (3) step();
        chk("rst_we", 32'(we_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        chk("rst_locked", 32'(locked_o), 0);
        rst = 1'b0;
        repeat (5) step();
        half(1'b1, 5, 0, 1'b0);
        half(1'b0, 5, 0, 1'b0);
        chk("rise_locked", 32'(locked_o), 1);
        for (int i = 0; i < 4; i++) begin
            half(1'b1, 5, 10, 1'b1);
            half(1'b0, 5, 0, 1'b0);
        end
        chk("rise_drain", 32'(q.size()), 0);
        chk("rise_data", 32'(data_o), 10);
        sel = 2'b11;
        half(1'b1, 5, 10, 1'b1);
        half(1'b0, 5, 5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            half(1'b1, 5, 5, 1'b1);
            half(1'b0, 5, 5, 1'b1);
        end
        chk("both_drain", 32'(q.size()), 0);
        sel = 2'b00;
        for (int i = 0; i < 30; i++) begin
            half(1'b1, 5, 0, 1'b0);
            half(1'b0, 5, 0, 1'b0);
        end
        chk("none_ovf", 32'(overflow_o), 1);
        chk("none_locked", 32'(locked_o), 1);
        chk("none_data", 32'(data_o), 5);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        chk("clr_ovf", 32'(overflow_o), 0);
        chk("clr_data", 32'(data_o), 0);
        chk("clr_locked", 32'(locked_o), 0);
        sel = 2'b01;
        repeat (4) step();
        half(1'b1, 5, 0, 1'b0);
        half(1'b0, 295, 0, 1'b0);
        chk("long_ovf", 32'(overflow_o), 1);
        half(1'b1, 5, 0, 1'b0);
        half(1'b0, 5, 0, 1'b0);
        half(1'b1, 5, 10, 1'b1);
        half(1'b0, 5, 0, 1'b0);
        chk("long_ovf_sticky", 32'(overflow_o), 1);
        chk("long_data", 32'(data_o), 10);
        chk("long_drain", 32'(q.size()), 0);
        min_iv = 8'd4;
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (5) step();
        gper(1'b0);
        gper(1'b1);
        gper(1'b1);
        chk("glitch_data", 32'(data_o), 20);
        chk("glitch_drain", 32'(q.size()), 0);
        min_iv = 8'd0;
        sig = 1'b1;
        step();
        step();
        clr = 1'b1;
        sig = 1'b0;
        step();
        clr = 1'b0;
        sig = 1'b1;
        step();
        chk("clredge_we", 32'(we_o), 0);
        repeat (4) step();
        chk("clredge_locked", 32'(locked_o), 0);
        chk("clredge_data", 32'(data_o), 0);
        chk("clredge_ovf", 32'(overflow_o), 0);
        sig = 1'b0;
        repeat (4) step();
        sig = 1'b1;
        repeat (4) step();
        chk("clredge_relock", 32'(locked_o), 1);
        sig = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        tog = 1'b1;
        half(1'b0, 12, 0, 1'b0);
        half(1'b1, 6, 0, 1'b0);
        half(1'b0, 6, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            half(1'b1, 6, 6, 1'b1);
            half(1'b0, 6, 0, 1'b0);
        end
        chk("clken_data", 32'(data_o), 6);
        chk("clken_drain", 32'(q.size()), 0);
        tog = 1'b0;
        clk_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        clk_en = 1'b1;
        chk("midrst_we", 32'(we_o), 0);
        chk("midrst_data", 32'(data_o), 0);
        chk("midrst_ovf", 32'(overflow_o), 0);
        chk("midrst_locked", 32'(locked_o), 0);
        repeat (3) step();
        chk("final_drain", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
